// File: rtl/piece_lock.sv
// Locks the active tetromino into the settled board, hands the merged board to
// the line-clear stage, and commits its result (or reports collision/timeout).
module piece_lock #(
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lock_req,
  input  logic [15:0]  piece_mask,
  input  logic [4:0]   piece_row,
  input  logic [3:0]   piece_col,
  input  logic [199:0] board_in,
  output logic         lc_start_eval,
  output logic [199:0] lc_array,
  input  logic         lc_eval_complete,
  input  logic [199:0] lc_output_array,
  output logic [199:0] board_out,
  output logic         busy,
  output logic         done,
  output logic         collision,
  output logic         timeout,
  output logic         game_over
);

  typedef enum logic [2:0] {IDLE, MERGE, START, WAIT, DONE} state_t;

  // Value of the wait counter in the last WAIT cycle allowed before aborting.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t       state;
  logic [15:0]  mask_q;
  logic [4:0]   row_q;
  logic [3:0]   col_q;
  logic [199:0] board_q;
  logic [7:0]   wait_cnt;

  logic [199:0] placed;
  logic         hit;
  logic [5:0]   cell_r;
  logic [5:0]   cell_c;
  logic [7:0]   cell_idx;

  // NOTE: every signal driven here gets a default before the loop, otherwise
  // paths that skip an assignment would infer latches.
  always_comb begin
    placed   = '0;
    hit      = 1'b0;
    cell_r   = '0;
    cell_c   = '0;
    cell_idx = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        cell_r = 6'(row_q) + 6'(i);
        cell_c = 6'(col_q) + 6'(j);
        if (mask_q[i*4+j]) begin
          if (cell_r > 6'd19 || cell_c > 6'd9) begin
            hit = 1'b1;
          end else begin
            cell_idx = 8'(cell_r) * 8'd10 + 8'(cell_c);
            if (board_q[cell_idx]) hit = 1'b1;
            placed[cell_idx] = 1'b1;
          end
        end
      end
    end
  end

  assign busy = (state != IDLE);

  // NOTE: all state and outputs update with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      mask_q        <= '0;
      row_q         <= '0;
      col_q         <= '0;
      board_q       <= '0;
      wait_cnt      <= '0;
      lc_array      <= '0;
      board_out     <= '0;
      lc_start_eval <= 1'b0;
      done          <= 1'b0;
      collision     <= 1'b0;
      timeout       <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_req && !game_over) begin
            mask_q  <= piece_mask;
            row_q   <= piece_row;
            col_q   <= piece_col;
            board_q <= board_in;
            state   <= MERGE;
          end
        end
        MERGE: begin
          if (hit) begin
            collision <= 1'b1;
            game_over <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            lc_array      <= board_q | placed;
            lc_start_eval <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          lc_start_eval <= 1'b0;
          wait_cnt      <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          // Completion takes priority over an expiring counter.
          if (lc_eval_complete) begin
            board_out <= lc_output_array;
            done      <= 1'b1;
            state     <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          collision <= 1'b0;
          timeout   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/piece_lock.md
PIECE_LOCK -- requirements
Module: piece_lock

Interface
- REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent in WAIT before the lock is aborted.
- REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
- REQ-003 clk  in  1  rising-edge clock.
- REQ-004 reset  in  1  synchronous active-high reset.
- REQ-005 lock_req  in  1  request to lock the active piece; sampled only in IDLE.
- REQ-006 piece_mask  in  16  4x4 piece box; bit i*4+j is box row i, column j.
- REQ-007 piece_row  in  5  board row of box row 0, range 0..19.
- REQ-008 piece_col  in  4  board column of box column 0, range 0..9.
- REQ-009 board_in  in  200  settled board; cell (r,c) is bit r*10+c; row 0 is the top row and row 19 the bottom row.
- REQ-010 lc_start_eval  out  1  start pulse to the line-clear stage.
- REQ-011 lc_array  out  200  merged board presented to the line-clear stage.
- REQ-012 lc_eval_complete  in  1  one-cycle completion pulse from the line-clear stage.
- REQ-013 lc_output_array  in  200  cleared board from the line-clear stage.
- REQ-014 board_out  out  200  committed board after the lock.
- REQ-015 busy  out  1  high in every state except IDLE.
- REQ-016 done  out  1  one-cycle pulse that ends every accepted lock.
- REQ-017 collision  out  1  valid with done; the piece could not be placed.
- REQ-018 timeout  out  1  valid with done; the line-clear stage did not respond in time.
- REQ-019 game_over  out  1  sticky flag, set on any collision.

Function
- REQ-020 The FSM SHALL have five states: IDLE, MERGE, START, WAIT and DONE.
- REQ-021 IDLE: lock_req=1 with game_over=0 SHALL latch piece_mask, piece_row, piece_col and board_in, then move to MERGE. lock_req is ignored in all other states and whenever game_over=1.
- REQ-022 MERGE (1 cycle) SHALL place mask bit i*4+j at cell (piece_row+i, piece_col+j), computed at 6-bit width.
- REQ-023 In MERGE, a set mask bit that lands at row >19, column >9, or an occupied latched-board cell SHALL count as a collision.
- REQ-024 On collision: set the collision flag and game_over, leave lc_array and board_out unchanged, go to DONE, and issue no start pulse.
- REQ-025 Without collision: lc_array <= latched board OR placed cells; go to START.
- REQ-026 START (1 cycle) SHALL hold lc_start_eval=1, then move to WAIT. lc_start_eval is 0 in all other states.
- REQ-027 WAIT: lc_eval_complete=1 SHALL load board_out <= lc_output_array and move to DONE.
- REQ-028 WAIT: an 8-bit counter, cleared on entry to WAIT, SHALL increment each cycle. When it reaches TIMEOUT with no completion, set the timeout flag, keep board_out, and go to DONE.
- REQ-029 If lc_eval_complete and the timeout condition occur in the same cycle, completion wins and timeout stays 0.
- REQ-030 DONE (1 cycle): done=1, with collision and timeout showing the flags from this lock; then go to IDLE and clear both flags.
- REQ-031 Latency without collision: lock_req in cycle 0, lc_start_eval in cycle 2, done one cycle after lc_eval_complete.
- REQ-032 Latency with collision: lock_req in cycle 0, done in cycle 2.
- REQ-033 done, collision and timeout SHALL be 0 outside DONE.
- REQ-034 lc_eval_complete seen outside WAIT SHALL be ignored.
- REQ-035 board_in changes after the latch point SHALL have no effect on the lock in progress.

Reset
- REQ-036 Reset SHALL put the FSM in IDLE and drive board_out, lc_array and all latches to 0. All 1-bit outputs, including game_over, SHALL be 0.
- REQ-037 Reset in any state, including mid-WAIT, SHALL abort the lock with no done pulse. game_over clears only on reset.

Verification
- V1 Reset asserted for 2 cycles -> every output 0 and busy=0.
- V2 Empty board, mask 0x0033, row 18, col 0 -> lc_array bits 180, 181, 190, 191 set; lc_start_eval only in cycle 2. Model returns the same array after 10 cycles -> done one cycle later, board_out equal to it, collision=0.
- V3 Board bits 190..195 set, mask 0x000F, row 19, col 6 -> lc_array row 19 equal to 0x3FF. Model returns row 19 cleared -> board_out equals the model output.
- V4 Board bit 0 set, mask 0x0001, row 0, col 0 -> no start pulse; done and collision in cycle 2; game_over=1; board_out unchanged. A later lock_req produces no busy.
- V5 Mask 0x000F, row 5, col 8 -> out-of-bounds collision, same response as V4.
- V6 Model never completes -> done with timeout=1 after TIMEOUT WAIT cycles and board_out unchanged. Repeat with reset mid-WAIT -> IDLE, no done pulse.
